alu_nibble_collector: RTL and testbench
=======================================

Name: alu_nibble_collector

Overview:
- Receiving end of the two 4-bit result lanes (lane 1, lane 2) that the ALU test design produces once per clock.
- Packs each accepted lane pair into one byte {IN2,IN1} and buffers it in a small FIFO.
- Counts bytes into frames of FRAME_LEN words.
- Drains to a downstream consumer over a valid/ready handshake, so lane activity can be monitored on-chip instead of only in simulation.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
FRAME_LEN, 8, data words per frame; 1..255
PTR_W, 2, log2(DEPTH); must be set consistently with DEPTH

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
IN_VALID  input  1  lane pair present this cycle
IN1  input  4  lane 1 nibble, packed into bits [3:0]
IN2  input  4  lane 2 nibble, packed into bits [7:4]
IN_READY  output  1  collector accepts the pair this cycle
OUT_VALID  output  1  OUT_DATA holds a buffered byte
OUT_DATA  output  8  head-of-FIFO byte
OUT_READY  input  1  consumer takes the head byte
OUT_LAST  output  1  head byte is the final byte of a frame
FRAME_CNT  output  8  completed frames, wraps 255->0
DROP_CNT  output  8  cycles with IN_VALID=1 and IN_READY=0; saturates at 255

Behaviour:
- Reset (RST_N low, asynchronous): FIFO empty, pointers 0, word counter 0, state COLLECT.
  - Output reset values: IN_READY=1, OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, FRAME_CNT=0, DROP_CNT=0.
  - Reset mid-frame discards all buffered data and the partial frame.
  - Release is taken at the first rising edge after RST_N goes high.
- Push: IN_VALID & IN_READY at a rising edge writes {IN2,IN1} to the tail, tail++ (mod DEPTH), word counter++.
- Pop: OUT_VALID & OUT_READY at a rising edge, head++ (mod DEPTH).
- Show-ahead FIFO: OUT_DATA/OUT_LAST reflect the head entry combinationally from storage; OUT_DATA=0 and OUT_LAST=0 when empty.
- Latency: a byte pushed at edge N shows OUT_VALID=1 after edge N. This is 1 cycle when empty.
- Each FIFO entry stores 9 bits: data plus a last flag.
- IN_READY = !full & (state==COLLECT). It does not look ahead at a same-cycle pop; when full, a pop frees space for the next cycle only.
- Simultaneous push and pop when neither full nor empty: both occur and occupancy is unchanged.
- Full/empty use an extra wrap bit on each pointer: full when the pointers are equal with differing wrap bits.
- Frame end (word counter reaches FRAME_LEN on a push):
  - the byte is stored with last=1;
  - the word counter resets to 0;
  - FRAME_CNT increments in the same edge.
- DROP_CNT increments on every edge where IN_VALID=1 and IN_READY=0, stopping at 255.
- State machine:
  - COLLECT: normal operation.
  - INSERT: exists only with the optional feature; IN_READY=0.
  - Without the feature the FSM stays in COLLECT.

Optional Feature:
- Macro: ALU_COLLECTOR_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of the frame's data bytes is kept and cleared at frame start and on reset.
  - The frame-ending data byte is stored with last=0.
  - The FSM enters INSERT on that edge.
  - In INSERT, once the FIFO is not full, the checksum (XOR including the final data byte) is pushed with last=1, the XOR is cleared, and the FSM returns to COLLECT.
  - IN_READY=0 throughout INSERT, so attempted pushes during INSERT count as drops.
  - FRAME_CNT increments when the checksum byte is pushed.
- Undefined: no checksum logic or INSERT state; frames carry FRAME_LEN bytes and the last data byte has last=1.

Test Plan:
- Reset then idle:
  - all outputs at reset values;
  - assert RST_N low mid-stream with 3 bytes buffered -> OUT_VALID=0, FRAME_CNT=0 immediately, without waiting for a clock edge.
- Single pair IN1=4'hA, IN2=4'h3, OUT_READY=1:
  - after 1 edge OUT_VALID=1, OUT_DATA=8'h3A;
  - popped next edge, then OUT_VALID=0.
- Fill with OUT_READY=0 and DEPTH=4, pushing 8'h01..8'h05:
  - after 4 pushes IN_READY=0 and DROP_CNT=1 for the 5th;
  - drain order 01,02,03,04.
- Steady stream with OUT_READY=1 and FRAME_LEN=8, bytes 8'h10..8'h17:
  - OUT_LAST=1 only on 8'h17;
  - FRAME_CNT=1; occupancy never exceeds 1.
- Checksum build (macro defined), FRAME_LEN=4, bytes 8'h01,02,04,08:
  - output sequence 01,02,04,08,0F;
  - OUT_LAST only on 0F;
  - IN_READY low for exactly one cycle after the 4th push.
- Drop saturation: IN_VALID=1 with the FIFO held full for 300 cycles -> DROP_CNT=255 and holds.

Source files
------------

// File: rtl/alu_nibble_collector.sv
`default_nettype none
// ============================================================================
// Module      : alu_nibble_collector
// Description : Receiving end of the ALU test design's two 4-bit result lanes.
//               Each accepted lane pair is packed into one byte {IN2,IN1},
//               buffered in a show-ahead FIFO together with a frame-last flag,
//               and drained over a valid/ready handshake. Bytes are counted
//               into frames of FRAME_LEN words; completed frames and dropped
//               input cycles are counted.
// Optional    : ALU_COLLECTOR_CHECKSUM_EN - append an XOR checksum byte to
//               every frame (the checksum byte carries the last flag).
// Ports       : CLK, RST_N (async, active low)
//               IN_VALID/IN1/IN2/IN_READY        - lane pair input
//               OUT_VALID/OUT_DATA/OUT_LAST/OUT_READY - byte output
//               FRAME_CNT (wrapping), DROP_CNT (saturating) - status
// Revision    : 1.0 - initial release
// ============================================================================
module alu_nibble_collector #(
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 8,
  parameter int PTR_W     = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       IN_VALID,
  input  logic [3:0] IN1,
  input  logic [3:0] IN2,
  output logic       IN_READY,
  output logic       OUT_VALID,
  output logic [7:0] OUT_DATA,
  input  logic       OUT_READY,
  output logic       OUT_LAST,
  output logic [7:0] FRAME_CNT,
  output logic [7:0] DROP_CNT
);

  localparam logic [7:0]   C_LAST_WORD = 8'(FRAME_LEN - 1);
  localparam logic [PTR_W:0] C_PTR_ONE = (PTR_W + 1)'(1);

`ifdef ALU_COLLECTOR_CHECKSUM_EN
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    INSERT  = 1'b1
  } state_t;
`else
  typedef enum logic [0:0] {
    COLLECT = 1'b0
  } state_t;
`endif

  state_t         state_q, state_d;
  logic [8:0]     mem_q [DEPTH];
  logic [8:0]     mem_d [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]     word_cnt_q, word_cnt_d;
  logic [7:0]     frame_cnt_q, frame_cnt_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;
`ifdef ALU_COLLECTOR_CHECKSUM_EN
  logic [7:0]     csum_q, csum_d;
`endif

  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic [8:0]     push_entry;
  logic [8:0]     head_entry;
  logic [7:0]     in_byte;

  assign in_byte    = {IN2, IN1};
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_entry = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Ready does not look ahead at a same-cycle pop.
  assign IN_READY   = !full && (state_q == COLLECT);
  assign OUT_VALID  = !empty;
  assign OUT_DATA   = empty ? 8'h00 : head_entry[7:0];
  assign OUT_LAST   = !empty && head_entry[8];
  assign FRAME_CNT  = frame_cnt_q;
  assign DROP_CNT   = drop_cnt_q;
  assign pop        = OUT_VALID && OUT_READY;

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    push        = 1'b0;
    push_entry  = 9'h000;
`ifdef ALU_COLLECTOR_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    if (IN_VALID && !IN_READY && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    if (IN_VALID && IN_READY) begin
      push       = 1'b1;
      push_entry = {1'b0, in_byte};
`ifdef ALU_COLLECTOR_CHECKSUM_EN
      csum_d     = csum_q ^ in_byte;
`endif
      if (word_cnt_q == C_LAST_WORD) begin
        word_cnt_d = 8'd0;
`ifdef ALU_COLLECTOR_CHECKSUM_EN
        // Final data byte stays unflagged; the checksum byte closes the frame.
        state_d = INSERT;
`else
        push_entry[8] = 1'b1;
        frame_cnt_d   = frame_cnt_q + 8'd1;
`endif
      end else begin
        word_cnt_d = word_cnt_q + 8'd1;
      end
    end

`ifdef ALU_COLLECTOR_CHECKSUM_EN
    // csum_q already includes the final data byte of the frame here.
    if ((state_q == INSERT) && !full) begin
      push        = 1'b1;
      push_entry  = {1'b1, csum_q};
      csum_d      = 8'h00;
      frame_cnt_d = frame_cnt_q + 8'd1;
      state_d     = COLLECT;
    end
`endif

    wr_ptr_d = push ? (wr_ptr_q + C_PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + C_PTR_ONE) : rd_ptr_q;

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_entry;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= COLLECT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      word_cnt_q  <= 8'd0;
      frame_cnt_q <= 8'd0;
      drop_cnt_q  <= 8'd0;
`ifdef ALU_COLLECTOR_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 9'h000;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      word_cnt_q  <= word_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef ALU_COLLECTOR_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_nibble_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_nibble_collector
// Description : Self-checking bench for alu_nibble_collector. A cycle model
//               predicts acceptance, framing and counters; expected bytes go
//               into a scoreboard queue and are compared when the DUT pops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_nibble_collector;

  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = 8;
  localparam int PTR_W     = 2;

  logic       CLK;
  logic       RST_N;
  logic       IN_VALID;
  logic [3:0] IN1;
  logic [3:0] IN2;
  logic       IN_READY;
  logic       OUT_VALID;
  logic [7:0] OUT_DATA;
  logic       OUT_READY;
  logic       OUT_LAST;
  logic [7:0] FRAME_CNT;
  logic [7:0] DROP_CNT;

  alu_nibble_collector #(
    .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN), .PTR_W(PTR_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN1(IN1), .IN2(IN2),
    .IN_READY(IN_READY), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA),
    .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST), .FRAME_CNT(FRAME_CNT),
    .DROP_CNT(DROP_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int         n_checks = 0;
  int         n_fail   = 0;

  // Reference model state
  logic [8:0] sb [$];
  int         m_count;
  int         m_word;
  bit         m_insert;
  logic [7:0] m_csum;
  logic [7:0] m_frames;
  int         m_drops;
  logic [8:0] mon_exp;

  task automatic model_clear();
    sb.delete();
    m_count  = 0;
    m_word   = 0;
    m_insert = 1'b0;
    m_csum   = 8'h00;
    m_frames = 8'h00;
    m_drops  = 0;
  endtask

  // Drive one cycle, advance the model, return at posedge+1.
  task automatic cycle(input bit v, input logic [7:0] byt, input bit ordy);
    bit         rdy;
    bit         do_push;
    bit         do_pop;
    logic [8:0] pe;
    IN_VALID  = v;
    IN1       = byt[3:0];
    IN2       = byt[7:4];
    OUT_READY = ordy;
    rdy     = (m_count < DEPTH) && !m_insert;
    do_pop  = (m_count != 0) && ordy;
    do_push = 1'b0;
    pe      = 9'h000;
    if (m_insert) begin
      if (m_count < DEPTH) begin
        do_push  = 1'b1;
        pe       = {1'b1, m_csum};
        m_csum   = 8'h00;
        m_insert = 1'b0;
        m_frames = m_frames + 8'd1;
      end
    end else if (v && rdy) begin
      do_push = 1'b1;
      pe      = {1'b0, byt};
      m_csum  = m_csum ^ byt;
      if (m_word == FRAME_LEN - 1) begin
        m_word = 0;
`ifdef ALU_COLLECTOR_CHECKSUM_EN
        m_insert = 1'b1;
`else
        pe[8]    = 1'b1;
        m_frames = m_frames + 8'd1;
`endif
      end else begin
        m_word = m_word + 1;
      end
    end
    if (v && !rdy && m_drops < 255) m_drops = m_drops + 1;
    @(posedge CLK);
    #1;
    if (do_push) sb.push_back(pe);
    m_count = m_count + int'(do_push) - int'(do_pop);
  endtask

  task automatic do_reset();
    IN_VALID  = 1'b0;
    IN1       = 4'h0;
    IN2       = 4'h0;
    OUT_READY = 1'b0;
    RST_N     = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    model_clear();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: the byte at the head is compared when a pop is about to occur.
  always @(negedge CLK) begin
    if (RST_N && OUT_VALID && OUT_READY) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_pop: DUT offered last=%b data=%h, expected no byte", OUT_LAST, OUT_DATA);
      end else begin
        mon_exp = sb.pop_front();
        if ({OUT_LAST, OUT_DATA} !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_pop: got last=%b data=%h, expected last=%b data=%h",
                   OUT_LAST, OUT_DATA, mon_exp[8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic test_reset();
    IN_VALID = 1'b0; IN1 = 4'h0; IN2 = 4'h0; OUT_READY = 1'b0;
    RST_N = 1'b0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if ({IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, FRAME_CNT, DROP_CNT} !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_hold: got rdy=%b vld=%b data=%h last=%b frm=%h drop=%h, expected 1 0 00 0 00 00",
               IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, FRAME_CNT, DROP_CNT);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, FRAME_CNT, DROP_CNT} !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_idle: got rdy=%b vld=%b data=%h last=%b frm=%h drop=%h, expected 1 0 00 0 00 00",
               IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, FRAME_CNT, DROP_CNT);
    end
  endtask

  task automatic test_single();
    do_reset();
    cycle(1'b1, 8'h3A, 1'b1);
    n_checks++;
    if ({OUT_VALID, OUT_DATA, OUT_LAST} !== {1'b1, 8'h3A, 1'b0}) begin
      n_fail++;
      $display("FAIL single_show: got vld=%b data=%h last=%b, expected 1 3a 0", OUT_VALID, OUT_DATA, OUT_LAST);
    end
    cycle(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({OUT_VALID, OUT_DATA} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL single_pop: got vld=%b data=%h, expected 0 00", OUT_VALID, OUT_DATA);
    end
  endtask

  task automatic test_fill();
    logic [7:0] b;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      cycle(1'b1, b, 1'b0);
    end
    n_checks++;
    if (IN_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full_ready: got %b expected 0", IN_READY);
    end
    cycle(1'b1, 8'h05, 1'b0);
    n_checks++;
    if (DROP_CNT !== 8'd1 || DROP_CNT !== 8'(m_drops)) begin
      n_fail++;
      $display("FAIL fill_drop: got %0d expected 1", DROP_CNT);
    end
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      n_checks++;
      if (OUT_DATA !== b) begin
        n_fail++;
        $display("FAIL fill_drain_order: got %h expected %h", OUT_DATA, b);
      end
      cycle(1'b0, 8'h00, 1'b1);
    end
    n_checks++;
    if (OUT_VALID !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL fill_empty: got vld=%b sb=%0d expected 0 0", OUT_VALID, sb.size());
    end
  endtask

  task automatic test_stream();
    logic [7:0] b;
    bit         exp_last;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      b = 8'h10 + 8'(i);
      cycle(1'b1, b, 1'b1);
`ifdef ALU_COLLECTOR_CHECKSUM_EN
      exp_last = 1'b0;
`else
      exp_last = (i == 7);
`endif
      n_checks++;
      if ({OUT_VALID, OUT_DATA, OUT_LAST} !== {1'b1, b, exp_last}) begin
        n_fail++;
        $display("FAIL stream_head[%0d]: got vld=%b data=%h last=%b, expected 1 %h %b",
                 i, OUT_VALID, OUT_DATA, OUT_LAST, b, exp_last);
      end
    end
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (FRAME_CNT !== 8'd1 || OUT_VALID !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stream_frame: got frm=%0d vld=%b sb=%0d, expected 1 0 0", FRAME_CNT, OUT_VALID, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    do_reset();
    cycle(1'b1, 8'hA1, 1'b0);
    cycle(1'b1, 8'hB2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      b = 8'hC0 + 8'(i);
      cycle(1'b1, b, 1'b1);
      n_checks++;
      if (OUT_VALID !== 1'b1 || m_count != 2 || IN_READY !== ((m_count < DEPTH) && !m_insert)) begin
        n_fail++;
        $display("FAIL b2b_occupancy[%0d]: got vld=%b rdy=%b model_cnt=%0d, expected 1 %b 2",
                 i, OUT_VALID, IN_READY, m_count, (m_count < DEPTH) && !m_insert);
      end
    end
    // Fill, then offer a push while popping: the push must be refused.
    while (m_count < DEPTH) cycle(1'b1, 8'hD0 + 8'(m_count), 1'b0);
    n_checks++;
    if (IN_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_full_ready: got %b expected 0", IN_READY);
    end
    cycle(1'b1, 8'hEE, 1'b1);
    n_checks++;
    if (DROP_CNT !== 8'(m_drops) || m_drops != 1 || IN_READY !== ((m_count < DEPTH) && !m_insert)) begin
      n_fail++;
      $display("FAIL b2b_no_lookahead: got drop=%0d rdy=%b, expected drop=1 rdy=%b",
               DROP_CNT, IN_READY, (m_count < DEPTH) && !m_insert);
    end
    repeat (6) cycle(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (OUT_VALID !== 1'b0 || sb.size() != 0 || FRAME_CNT !== m_frames) begin
      n_fail++;
      $display("FAIL b2b_drain: got vld=%b sb=%0d frm=%0d, expected 0 0 %0d", OUT_VALID, sb.size(), FRAME_CNT, m_frames);
    end
  endtask

`ifdef ALU_COLLECTOR_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      b = 8'h01 << i;
      cycle(1'b1, b, 1'b1);
    end
    n_checks++;
    if ({IN_READY, OUT_DATA, OUT_LAST} !== {1'b0, 8'h80, 1'b0}) begin
      n_fail++;
      $display("FAIL csum_insert: got rdy=%b data=%h last=%b, expected 0 80 0", IN_READY, OUT_DATA, OUT_LAST);
    end
    // Push attempt during INSERT is dropped.
    cycle(1'b1, 8'h55, 1'b1);
    n_checks++;
    if ({IN_READY, OUT_DATA, OUT_LAST, FRAME_CNT, DROP_CNT} !== {1'b1, 8'hFF, 1'b1, 8'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL csum_byte: got rdy=%b data=%h last=%b frm=%0d drop=%0d, expected 1 ff 1 1 1",
               IN_READY, OUT_DATA, OUT_LAST, FRAME_CNT, DROP_CNT);
    end
    repeat (2) cycle(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (OUT_VALID !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL csum_drain: got vld=%b sb=%0d expected 0 0", OUT_VALID, sb.size());
    end
  endtask
`endif

  task automatic test_drop_sat();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0);
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 8'h77, 1'b0);
      if (i == 253 || i == 254 || i == 299) begin
        n_checks++;
        if (DROP_CNT !== ((i == 253) ? 8'd254 : 8'd255)) begin
          n_fail++;
          $display("FAIL drop_sat[%0d]: got %0d expected %0d", i, DROP_CNT, (i == 253) ? 254 : 255);
        end
      end
    end
    repeat (DEPTH + 1) cycle(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (DROP_CNT !== 8'd255 || OUT_VALID !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL drop_hold: got drop=%0d vld=%b sb=%0d, expected 255 0 0", DROP_CNT, OUT_VALID, sb.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < FRAME_LEN; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h90 + 8'(i), 1'b0);
    n_checks++;
    if (FRAME_CNT !== 8'd1 || OUT_VALID !== 1'b1 || OUT_DATA !== 8'h90) begin
      n_fail++;
      $display("FAIL async_pre: got frm=%0d vld=%b data=%h, expected 1 1 90", FRAME_CNT, OUT_VALID, OUT_DATA);
    end
    #2;
    RST_N = 1'b0;
    #1;
    n_checks++;
    if ({OUT_VALID, OUT_DATA, FRAME_CNT, IN_READY} !== {1'b0, 8'h00, 8'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset: got vld=%b data=%h frm=%0d rdy=%b, expected 0 00 0 1",
               OUT_VALID, OUT_DATA, FRAME_CNT, IN_READY);
    end
    model_clear();
    @(negedge CLK);
    RST_N = 1'b1;
    cycle(1'b1, 8'h4C, 1'b0);
    n_checks++;
    if ({OUT_VALID, OUT_DATA} !== {1'b1, 8'h4C}) begin
      n_fail++;
      $display("FAIL async_release: got vld=%b data=%h, expected 1 4c", OUT_VALID, OUT_DATA);
    end
    cycle(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (OUT_VALID !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL async_drain: got vld=%b sb=%0d expected 0 0", OUT_VALID, sb.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_back_to_back();
`ifdef ALU_COLLECTOR_CHECKSUM_EN
    test_checksum();
`endif
    test_drop_sat();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
